// File: rtl/window_gen_pkg.sv
// window_gen_pkg
//   Shared definitions for the sliding-window generator: default geometry
//   constants and the fill/stream state encoding.
//   Optional feature macro used elsewhere: WINDOW_GEN_FRAME_CNT_EN.
package window_gen_pkg;

  localparam int DEFAULT_WIN       = 3;
  localparam int DEFAULT_DATA_SIZE = 8;
  localparam int DEFAULT_IMG_W     = 64;
  localparam int DEFAULT_IMG_H     = 48;

  // FILL: line buffers still priming for the current frame.
  // STREAM: enough rows seen that windows can be produced.
  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } win_state_t;

endpackage

// File: rtl/window_gen_if.sv
// window_gen_if
//   Handshake bundle for window_gen.
//   Pixel side : pix_in, pix_valid, pix_sof (to generator), pix_ready (from generator)
//   Window side: win_out, win_valid, frame_done (from generator), win_ready (to generator)
//   master modport = pixel source / window sink, slave modport = the generator.
interface window_gen_if import window_gen_pkg::*; #(
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int WIN_SIZE  = DEFAULT_WIN * DEFAULT_WIN
);

  logic [DATA_SIZE-1:0]          pix_in;
  logic                          pix_valid;
  logic                          pix_sof;
  logic                          pix_ready;
  logic [DATA_SIZE*WIN_SIZE-1:0] win_out;
  logic                          win_valid;
  logic                          win_ready;
  logic                          frame_done;

  modport master (
    output pix_in, pix_valid, pix_sof, win_ready,
    input  pix_ready, win_out, win_valid, frame_done
  );

  modport slave (
    input  pix_in, pix_valid, pix_sof, win_ready,
    output pix_ready, win_out, win_valid, frame_done
  );

endinterface

// File: rtl/window_gen_line_buffer.sv
// line_buffer
//   One-row delay line addressed by column. Reading address c returns the
//   pixel written at column c during the previous row; on en the current
//   pixel replaces it. Contents are intentionally not reset.
//   Ports: clk, en (pixel accepted), addr (column), din, dout (previous row).
module line_buffer #(
  parameter  int DEPTH     = 64,
  parameter  int DATA_SIZE = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_SIZE-1:0] din,
  output logic [DATA_SIZE-1:0] dout
);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Column-addressed storage keeps rows aligned even when a frame restarts
  // mid-row, since the address is always the column of the pixel in flight.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[addr] <= din;
    end
  end

  // Combinational read so the old row value is available in the accept cycle.
  assign dout = mem[addr];

endmodule

// File: rtl/window_gen.sv
// window_gen
//   Sliding WIN x WIN window generator over a raster pixel stream.
//   Ports: clk, rst (async, active-high), bus (window_gen_if.slave: pixel
//   input handshake, flattened window output handshake, frame_done pulse).
//   Macro WINDOW_GEN_FRAME_CNT_EN adds output frame_cnt[15:0], counting
//   frame_done pulses.
module window_gen import window_gen_pkg::*; #(
  parameter int WIN       = DEFAULT_WIN,
  parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
  parameter int IMG_W     = DEFAULT_IMG_W,
  parameter int IMG_H     = DEFAULT_IMG_H
) (
  input logic        clk,
  input logic        rst,
  window_gen_if.slave bus
`ifdef WINDOW_GEN_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int WIN_SIZE = WIN * WIN;
  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);

  win_state_t           state;
  logic [COL_W-1:0]     col;
  logic [ROW_W-1:0]     row;
  logic [COL_W-1:0]     eff_col;
  logic [ROW_W-1:0]     eff_row;
  logic                 accept;
  logic                 last_col;
  logic                 last_row;
  logic                 win_fire;
  logic [DATA_SIZE-1:0] tap     [WIN-1];
  logic [DATA_SIZE-1:0] new_col [WIN];
  logic [DATA_SIZE-1:0] win     [WIN][WIN];

  // A held window blocks new pixels, so the window register never changes
  // underneath a stalled consumer.
  assign bus.pix_ready = !bus.win_valid | bus.win_ready;
  assign accept        = bus.pix_valid & bus.pix_ready;

  // A start-of-frame pixel is positioned at (0,0) regardless of the counters.
  assign eff_col  = bus.pix_sof ? '0 : col;
  assign eff_row  = bus.pix_sof ? '0 : row;
  assign last_col = (eff_col == COL_W'(IMG_W - 1));
  assign last_row = (eff_row == ROW_W'(IMG_H - 1));

  // STREAM only holds from row WIN-1 onward, so only the column needs testing.
  assign win_fire = (state == STREAM) && !bus.pix_sof && (eff_col >= COL_W'(WIN - 1));

  for (genvar i = 0; i < WIN - 1; i++) begin : g_lb
    logic [DATA_SIZE-1:0] lb_din;
    if (i == 0) begin : g_first
      assign lb_din = bus.pix_in;
    end else begin : g_chain
      assign lb_din = tap[i-1];
    end
    line_buffer #(
      .DEPTH     (IMG_W),
      .DATA_SIZE (DATA_SIZE)
    ) u_lb (
      .clk  (clk),
      .en   (accept),
      .addr (eff_col),
      .din  (lb_din),
      .dout (tap[i])
    );
  end

  // Incoming column for the window, top row first: the oldest line buffer
  // feeds the top row and the live pixel feeds the bottom row.
  assign new_col[WIN-1] = bus.pix_in;
  for (genvar r = 0; r < WIN - 1; r++) begin : g_col
    assign new_col[r] = tap[WIN-2-r];
  end

  // Position counters, fill/stream FSM and the registered handshake outputs
  // all advance together on an accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= FILL;
      col            <= '0;
      row            <= '0;
      bus.win_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : eff_row + ROW_W'(1);
        end else begin
          col <= eff_col + COL_W'(1);
          row <= eff_row;
        end
        bus.win_valid  <= win_fire;
        bus.frame_done <= last_col && last_row;
        case (state)
          FILL: begin
            if (last_col && (eff_row == ROW_W'(WIN - 2))) begin
              state <= STREAM;
            end
          end
          STREAM: begin
            if (bus.pix_sof || (last_col && last_row)) begin
              state <= FILL;
            end
          end
          default: state <= FILL;
        endcase
      end else if (bus.win_ready) begin
        bus.win_valid <= 1'b0;
      end
    end
  end

  // Window shift register: every accepted pixel shifts the window one
  // column left and loads the new column on the right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < WIN; r++) begin
        for (int c = 0; c < WIN - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][WIN-1] <= new_col[r];
      end
    end
  end

  // Flatten row-major, element 0 = top-left.
  always_comb begin
    bus.win_out = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        bus.win_out[DATA_SIZE*(r*WIN+c) +: DATA_SIZE] = win[r][c];
      end
    end
  end

`ifdef WINDOW_GEN_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (bus.frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_window_gen.sv
// tb_window_gen
//   Directed bench for window_gen at IMG_W=8, IMG_H=6, WIN=3 with pixel
//   value = row*8 + col + frame base. A frame-level image model predicts
//   every output each cycle; literal expectations pin the key windows.
module tb_window_gen;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int K  = 3;
  localparam int DS = 8;
  localparam int KS = K * K;

  logic clk;
  logic rst;

  window_gen_if #(.DATA_SIZE(DS), .WIN_SIZE(KS)) bus ();

`ifdef WINDOW_GEN_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  window_gen #(
    .WIN       (K),
    .DATA_SIZE (DS),
    .IMG_W     (W),
    .IMG_H     (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WINDOW_GEN_FRAME_CNT_EN
    ,
    .frame_cnt (frame_cnt)
`endif
  );

  int checks    = 0;
  int failures  = 0;
  int win_count = 0;

  // Image model: the current frame as accepted, plus the expected outputs.
  logic [DS-1:0]    img [H][W];
  int               mr = 0;
  int               mc = 0;
  logic             exp_valid = 1'b0;
  logic             exp_done  = 1'b0;
  logic [DS*KS-1:0] exp_win   = '0;
  logic [15:0]      exp_cnt   = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [DS*KS-1:0] actual,
                             input logic [DS*KS-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [DS*KS-1:0] kpix(input logic [DS*KS-1:0] w, input int k);
    return {{(DS*KS-DS){1'b0}}, w[DS*k +: DS]};
  endfunction

  // Compare every cycle, then advance the model by what the next edge does.
  always @(negedge clk) begin
    logic acc;
    logic nxt_done;
    if (rst) begin
      mr = 0; mc = 0; exp_valid = 1'b0; exp_done = 1'b0; exp_cnt = '0;
      checkOutput("rst_win_valid", bus.win_valid, 1'b0);
      checkOutput("rst_frame_done", bus.frame_done, 1'b0);
      checkOutput("rst_pix_ready", bus.pix_ready, 1'b1);
      checkOutput("rst_win_out", bus.win_out, '0);
    end else begin
      checkOutput("win_valid", bus.win_valid, exp_valid);
      checkOutput("pix_ready", bus.pix_ready, !exp_valid || bus.win_ready);
      checkOutput("frame_done", bus.frame_done, exp_done);
      if (exp_valid) checkOutput("win_out", bus.win_out, exp_win);
`ifdef WINDOW_GEN_FRAME_CNT_EN
      checkOutput("frame_cnt", frame_cnt, exp_cnt);
`endif
      if (bus.win_valid && bus.win_ready) win_count++;
      acc = bus.pix_valid && (!exp_valid || bus.win_ready);
      if (exp_done) exp_cnt = exp_cnt + 16'd1;
      nxt_done = 1'b0;
      if (acc) begin
        if (bus.pix_sof) begin mr = 0; mc = 0; end
        img[mr][mc] = bus.pix_in;
        if (mr >= K - 1 && mc >= K - 1) begin
          exp_valid = 1'b1;
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              exp_win[DS*(i*K+j) +: DS] = img[mr-K+1+i][mc-K+1+j];
        end else begin
          exp_valid = 1'b0;
        end
        nxt_done = (mr == H - 1) && (mc == W - 1);
        if (mc == W - 1) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
          mc++;
        end
      end else if (bus.win_ready) begin
        exp_valid = 1'b0;
      end
      exp_done = nxt_done;
    end
  end

  // Present one pixel until accepted; entered and left just after a rising edge.
  task automatic applyStimulus(input logic [DS-1:0] p, input logic sof);
    int n;
    bus.pix_in = p; bus.pix_sof = sof; bus.pix_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.pix_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pix_ready) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: pix_ready=0 required 1");
    end
    @(posedge clk); #1;
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_in = 8'h5A;
  endtask

  function automatic logic [DS-1:0] pixVal(input int r, input int c, input int base);
    return DS'((r * W + c + base) & 255);
  endfunction

  task automatic peekFirst(input int base, input int start_cnt);
    @(negedge clk); #1;
    checkOutput("first_valid", bus.win_valid, 1'b1);
    checkOutput("first_k0", kpix(bus.win_out, 0), base);
    checkOutput("first_k4", kpix(bus.win_out, 4), base + 9);
    checkOutput("first_k8", kpix(bus.win_out, 8), base + 18);
    checkOutput("first_count", win_count - start_cnt, 1);
    @(posedge clk); #1;
  endtask

  task automatic peekLast(input int base, input int start_cnt);
    @(negedge clk); #1;
    checkOutput("last_valid", bus.win_valid, 1'b1);
    checkOutput("last_k8", kpix(bus.win_out, 8), base + 47);
    checkOutput("last_frame_done", bus.frame_done, 1'b1);
    checkOutput("frame_windows", win_count - start_cnt, 24);
    @(posedge clk); #1;
  endtask

  // Hold the consumer off for five edges with the next pixel already offered.
  task automatic stallWindow(input int base);
    bus.win_ready = 1'b0;
    bus.pix_in = pixVal(3, 5, base); bus.pix_valid = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      checkOutput("stall_valid", bus.win_valid, 1'b1);
      checkOutput("stall_k8", kpix(bus.win_out, 8), base + 28);
      checkOutput("stall_pix_ready", bus.pix_ready, 1'b0);
    end
    @(posedge clk); #1;
    bus.win_ready = 1'b1;
  endtask

  task automatic runFrame(input int base, input int first_idx, input int last_idx,
                          input bit stall, input bit gaps, input int start_cnt);
    for (int i = first_idx; i <= last_idx; i++) begin
      int r;
      int c;
      r = i / W;
      c = i % W;
      applyStimulus(pixVal(r, c, base), 1'b0);
      if (r == 2 && c == 2) peekFirst(base, start_cnt);
      if (stall && r == 3 && c == 4) stallWindow(base);
      if (r == H - 1 && c == W - 1) peekLast(base, start_cnt);
      if (gaps && c == W - 1) begin
        repeat (2) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    int start;
    rst = 1'b1;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] frame 1: plain raster, idle gaps, backpressure");
    start = win_count;
    runFrame(0, 0, W * H - 1, 1'b1, 1'b1, start);

    $display("[TB] frame 2: reset pulse at (4,3)");
    start = win_count;
    runFrame(3, 0, 4 * W + 2, 1'b0, 1'b0, start);
    bus.pix_in = pixVal(4, 3, 3); bus.pix_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk); #1;
    checkOutput("pulse_win_valid", bus.win_valid, 1'b0);
    checkOutput("pulse_frame_done", bus.frame_done, 1'b0);
    checkOutput("pulse_pix_ready", bus.pix_ready, 1'b1);
    checkOutput("pulse_win_out", bus.win_out, '0);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    $display("[TB] frame 3: full frame after reset");
    start = win_count;
    runFrame(50, 0, W * H - 1, 1'b0, 1'b0, start);

    $display("[TB] frame 4/5: sof restart at (3,5)");
    start = win_count;
    runFrame(0, 0, 3 * W + 4, 1'b0, 1'b0, start);
    applyStimulus(pixVal(0, 0, 100), 1'b1);
    start = win_count;
    runFrame(100, 1, W * H - 1, 1'b0, 1'b1, start);

    $display("[TB] frame 6: full frame");
    start = win_count;
    runFrame(7, 0, W * H - 1, 1'b0, 1'b0, start);

    repeat (3) @(posedge clk);
    #1;
`ifdef WINDOW_GEN_FRAME_CNT_EN
    checkOutput("frame_cnt_three", frame_cnt, 16'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so a wedged DUT still reaches the summary.
  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/window_gen.md
WINDOW_GEN -- requirements
Module: window_gen

Interface
REQ-001 SHALL have parameter WIN, default 3, meaning window edge length in pixels (odd, >=3).
REQ-002 SHALL have parameter DATA_SIZE, default 8, meaning pixel width in bits.
REQ-003 SHALL have parameter IMG_W, default 64, meaning image width in pixels (>=WIN).
REQ-004 SHALL have parameter IMG_H, default 48, meaning image height in pixels (>=WIN).
REQ-005 SHALL have derived localparam WIN_SIZE = WIN*WIN.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-008 SHALL have port pix_in, input, DATA_SIZE, raster-order pixel.
REQ-009 SHALL have port pix_valid, input, 1, pix_in valid.
REQ-010 SHALL have port pix_sof, input, 1, marks pix_in as pixel (0,0); qualified by pix_valid.
REQ-011 SHALL have port pix_ready, output, 1, pixel accepted when pix_valid & pix_ready.
REQ-012 SHALL have port win_out, output, DATA_SIZE*WIN_SIZE, flattened window; element k at bits [DATA_SIZE*k +: DATA_SIZE], k row-major, k=0 top-left, k=WIN_SIZE-1 bottom-right.
REQ-013 SHALL have port win_valid, output, 1, win_out valid.
REQ-014 SHALL have port win_ready, input, 1, window consumed when win_valid & win_ready.
REQ-015 SHALL have port frame_done, output, 1, one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-016 SHALL track column (0..IMG_W-1) and row (0..IMG_H-1) counters advancing only on accepted pixels; column wraps to 0 and row increments at IMG_W-1; both wrap to 0 after (IMG_W-1, IMG_H-1).
REQ-017 SHALL hold WIN-1 previous rows in line buffers and a WIN x WIN shift register of pixels.
REQ-018 SHALL assert win_valid, on the cycle after accepting pixel (row,col), iff row>=WIN-1 and col>=WIN-1; the window covers rows row-WIN+1..row and cols col-WIN+1..col; border pixels produce no window.
REQ-019 SHALL emit exactly (IMG_W-WIN+1)*(IMG_H-WIN+1) windows per frame.
REQ-020 SHALL drive pix_ready = !win_valid | win_ready; win_out and win_valid SHALL hold stable while win_valid & !win_ready.
REQ-021 SHALL implement FSM FILL -> STREAM when an accepted pixel completes row WIN-2; STREAM -> FILL on accepting the frame's last pixel; FILL otherwise holds.
REQ-022 SHALL, on accepted pix_sof at any position, treat that pixel as (0,0), enter FILL, and emit no window containing pre-sof data.
REQ-023 SHALL pulse frame_done the cycle after acceptance of pixel (IMG_H-1, IMG_W-1), concurrent with that frame's final win_valid.
REQ-024 SHALL ignore pix_in when pix_valid is low; no counter or buffer change.

Reset
REQ-025 SHALL on rst force: FSM=FILL, counters=0, win_valid=0, frame_done=0, win_out=0, pix_ready=1; line-buffer contents need not be cleared.
REQ-026 SHALL treat rst asserted mid-frame as abandoning the frame; the first accepted pixel after release is (0,0).

Configuration
REQ-027 SHALL, with macro WINDOW_GEN_FRAME_CNT_EN defined, add output frame_cnt [15:0], reset 0, incrementing (wrapping at 65535) with each frame_done pulse; without it the port and counter SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place default WIN, DATA_SIZE, IMG_W, IMG_H constants and the FSM state encoding in shared package window_gen_pkg.
REQ-029 SHALL instantiate WIN-1 copies of sub-module line_buffer (IMG_W-deep, DATA_SIZE-wide, one-row delay, write/read on accept enable).

Verification (IMG_W=8, IMG_H=6, WIN=3, pixel=row*8+col, win_ready=1)
REQ-030 SHALL check first window: after accepting (2,2), next cycle win_valid=1, k0=0, k4=9, k8=18; no win_valid earlier.
REQ-031 SHALL check full frame: exactly 24 windows, last window k8=47, frame_done coincident with it.
REQ-032 SHALL check backpressure: win_ready=0 for 5 cycles on window (3,4) -> pix_ready=0, win_out stable k8=28, no pixel lost.
REQ-033 SHALL check rst pulse at pixel (4,3) -> outputs reset values; next frame yields 24 correct windows.
REQ-034 SHALL check pix_sof at (3,5) -> no window until restarted pixel (2,2); windows then match new frame.
REQ-035 SHALL check with WINDOW_GEN_FRAME_CNT_EN: three frames -> frame_cnt=3.
